// File: rtl/puf_seq_pkg.sv
// Shared types and helpers for the PUF challenge sequencer.
// State encoding, LFSR polynomial, zero-seed substitute and pair derivation.
package puf_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESET,
    S_RUN,
    S_SAMPLE,
    S_NEXT,
    S_DONE
  } state_t;

  // x^16+x^14+x^13+x^11+1 -> taps on bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Returns {select2, select1}; an equal pair gets select2 nudged apart.
  function automatic logic [7:0] pair_of(
    input logic [15:0] s
  );
    logic [3:0] a;
    logic [3:0] b;
    a = s[3:0];
    b = s[7:4];
    if (b == a) b = a ^ 4'h1;
    return {b, a};
  endfunction

endpackage

// File: rtl/puf_lfsr16.sv
// 16-bit Fibonacci LFSR that expands the challenge seed.
// Load has priority over step; reset state is the zero-seed substitute.
module puf_lfsr16
  import puf_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= LFSR_ZERO_SUB;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF challenge sequencer: LFSR pairs, timed evaluations.
// Define PUF_SEQ_MAJORITY_EN for 2-of-3 majority evaluation per pair.
module puf_challenge_sequencer
  import puf_seq_pkg::*;
#(
  parameter int RESP_BITS     = 32,
  parameter int RST_CYCLES    = 4,
  parameter int WINDOW_CYCLES = 4095,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          seed,
  input  logic                 puf_in,
  output logic [3:0]           ro_select1,
  output logic [3:0]           ro_select2,
  output logic                 ro_enable,
  output logic                 ro_reset,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] resp_data
);

  if (RESP_BITS < 1 || RESP_BITS > 64 ||
      RST_CYCLES < 1 || RST_CYCLES > 65535 ||
      SETTLE_CYCLES < 3 ||
      WINDOW_CYCLES + SETTLE_CYCLES > 65535) begin : g_bad_params
    $error("puf_challenge_sequencer: illegal parameter set");
  end

  localparam logic [15:0] RST_LD = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RUN_LD =
    16'(WINDOW_CYCLES + SETTLE_CYCLES - 1);

  state_t                r_state;
  logic [15:0]           r_timer;
  logic [6:0]            r_idx;
  logic [3:0]            r_sel1;
  logic [3:0]            r_sel2;
  logic                  r_en;
  logic                  r_rst;
  logic                  r_busy;
  logic                  r_valid;
  logic [RESP_BITS-1:0]  r_resp;
  logic                  r_sync1;
  logic                  r_sync2;

  logic [15:0]           w_lfsr;
  logic [15:0]           w_seed_eff;
  logic                  w_load;
  logic                  w_last_eval;
  logic                  w_step;
  logic                  w_bit;
  logic [6:0]            w_idx_nxt;

`ifdef PUF_SEQ_MAJORITY_EN
  logic [1:0]            r_eval;
  logic [1:0]            r_votes;
  assign w_last_eval = (r_eval == 2'd2);
  assign w_bit = (r_votes == 2'd2) ||
                 ((r_votes == 2'd1) && r_sync2);
`else
  assign w_last_eval = 1'b1;
  assign w_bit       = r_sync2;
`endif

  assign w_seed_eff = (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
  assign w_load     = (r_state == S_IDLE) && start;
  assign w_step     = (r_state == S_SAMPLE) && w_last_eval;
  assign w_idx_nxt  = r_idx + 7'd1;

  puf_lfsr16 u_lfsr (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_load  (w_load),
    .i_seed  (w_seed_eff),
    .i_step  (w_step),
    .o_state (w_lfsr)
  );

  // puf_in is asynchronous to clock
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= puf_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_sel1  <= '0;
      r_sel2  <= '0;
      r_en    <= 1'b0;
      r_rst   <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_resp  <= '0;
`ifdef PUF_SEQ_MAJORITY_EN
      r_eval  <= '0;
      r_votes <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state          <= S_PRESET;
            r_timer          <= RST_LD;
            r_idx            <= '0;
            r_resp           <= '0;
            r_busy           <= 1'b1;
            r_rst            <= 1'b1;
            r_en             <= 1'b0;
            {r_sel2, r_sel1} <= pair_of(w_seed_eff);
          end
        end
        S_PRESET: begin
          if (r_timer == 16'd0) begin
            r_state <= S_RUN;
            r_timer <= RUN_LD;
            r_rst   <= 1'b0;
            r_en    <= 1'b1;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_RUN: begin
          if (r_timer == 16'd0) begin
            r_state <= S_SAMPLE;
            r_timer <= '0;
            r_en    <= 1'b0;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_SAMPLE: begin
          r_timer <= '0;
          if (w_last_eval) begin
            for (int i = 0; i < RESP_BITS; i++) begin
              if (r_idx == 7'(i)) r_resp[i] <= w_bit;
            end
            r_state          <= S_NEXT;
            {r_sel2, r_sel1} <= pair_of(lfsr_step(w_lfsr));
`ifdef PUF_SEQ_MAJORITY_EN
            r_eval  <= '0;
            r_votes <= '0;
          end else begin
            r_eval  <= r_eval + 2'd1;
            r_votes <= r_votes + {1'b0, r_sync2};
            r_state <= S_PRESET;
            r_timer <= RST_LD;
            r_rst   <= 1'b1;
`endif
          end
        end
        S_NEXT: begin
          r_idx <= w_idx_nxt;
          r_rst <= 1'b1;
          if (w_idx_nxt == 7'(RESP_BITS)) begin
            r_state <= S_DONE;
            r_timer <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_PRESET;
            r_timer <= RST_LD;
          end
        end
        S_DONE: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
          end else if (resp_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
            r_timer <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ro_select1 = r_sel1;
  assign ro_select2 = r_sel2;
  assign ro_enable  = r_en;
  assign ro_reset   = r_rst;
  assign busy       = r_busy;
  assign resp_valid = r_valid;
  assign resp_data  = r_resp;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: a default-timing single-bit instance
// plus a short-window 8-bit instance checked against a response model.
module tb_puf_challenge_sequencer;

  localparam int BB = 8;
  localparam int BR = 2;
  localparam int BW = 20;
  localparam int BS = 3;
`ifdef PUF_SEQ_MAJORITY_EN
  localparam int A_PER = 3 * (4 + 4095 + 8 + 1) + 1;
  localparam int B_PER = 3 * (BR + BW + BS + 1) + 1;
  localparam int EPB   = 3;
`else
  localparam int A_PER = 4 + 4095 + 8 + 2;
  localparam int B_PER = BR + BW + BS + 2;
  localparam int EPB   = 1;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        a_start, a_puf, a_en, a_rst, a_busy, a_valid, a_ready;
  logic [15:0] a_seed;
  logic [3:0]  a_sel1, a_sel2;
  logic [0:0]  a_data;
  logic        b_start, b_puf, b_en, b_rst, b_busy, b_valid, b_ready;
  logic [15:0] b_seed;
  logic [3:0]  b_sel1, b_sel2;
  logic [BB-1:0] b_data;

  logic a_glitch_on = 1'b0;
  int   a_evals = 0, a_base = 0, b_evals = 0;
  logic a_en_q, b_en_q;

  int checks = 0;
  int errors = 0;

  puf_challenge_sequencer #(.RESP_BITS(1)) u_a (
    .clock(clock), .reset_n(reset_n), .start(a_start), .seed(a_seed),
    .puf_in(a_puf), .ro_select1(a_sel1), .ro_select2(a_sel2),
    .ro_enable(a_en), .ro_reset(a_rst), .busy(a_busy),
    .resp_valid(a_valid), .resp_ready(a_ready), .resp_data(a_data)
  );

  puf_challenge_sequencer #(
    .RESP_BITS(BB), .RST_CYCLES(BR),
    .WINDOW_CYCLES(BW), .SETTLE_CYCLES(BS)
  ) u_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .seed(b_seed),
    .puf_in(b_puf), .ro_select1(b_sel1), .ro_select2(b_sel2),
    .ro_enable(b_en), .ro_reset(b_rst), .busy(b_busy),
    .resp_valid(b_valid), .resp_ready(b_ready), .resp_data(b_data)
  );

  // PUF model: the oscillator with the larger index wins
  assign a_puf = (a_sel1 > a_sel2) ^
                 (a_glitch_on && (a_evals - a_base == 2));
  assign b_puf = (b_sel1 > b_sel2);

  always @(negedge clock) begin
    a_en_q <= a_en;
    b_en_q <= b_en;
    if (a_en && !a_en_q) a_evals <= a_evals + 1;
    if (b_en && !b_en_q) b_evals <= b_evals + 1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [63:0] m_resp(input logic [15:0] sd,
                                         input int n);
    logic [15:0] s;
    logic [63:0] r;
    int a, b;
    s = (sd == 16'h0) ? 16'hACE1 : sd;
    r = '0;
    for (int i = 0; i < n; i++) begin
      a = int'(s[3:0]);
      b = int'(s[7:4]);
      if (a == b) b = a ^ 1;
      r[i] = (a > b);
      s = m_step(s);
    end
    return r;
  endfunction

  typedef struct {
    logic [15:0] seed;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        b;
  } vec_t;

  vec_t        tbl[5];
  int          lat;
  logic [15:0] sd;
  logic [63:0] exp64;
  logic [BB-1:0] snap;
  logic        stable, seen;

  initial begin
    tbl[0] = '{16'h0021, 4'd1, 4'd2,  1'b0};
    tbl[1] = '{16'h0033, 4'd3, 4'd2,  1'b1};
    tbl[2] = '{16'h0000, 4'd1, 4'd14, 1'b0};
    tbl[3] = '{16'h0059, 4'd9, 4'd5,  1'b1};
    tbl[4] = '{16'h0088, 4'd8, 4'd9,  1'b0};

    a_start = 0; a_seed = 0; a_ready = 0;
    b_start = 0; b_seed = 0; b_ready = 0;
    reset_n = 0;
    repeat (3) @(negedge clock);
    chk("rst_a", {a_sel1, a_sel2, a_en, a_rst, a_busy, a_valid, a_data},
        {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("rst_b", {b_sel1, b_sel2, b_en, b_rst, b_busy, b_valid, b_data},
        {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    reset_n = 1;

    for (int v = 0; v < 5; v++) begin
      @(negedge clock);
      a_seed = tbl[v].seed; a_start = 1;
      @(negedge clock);
      a_start = 0;
      chk("acc_state", {a_busy, a_rst, a_en}, 3'b110);
      chk("sel", {a_sel1, a_sel2}, {tbl[v].s1, tbl[v].s2});
      lat = 0;
      while (!a_valid && lat < A_PER + 100) begin
        @(negedge clock); lat++;
      end
      chk("a_latency", 64'(lat), 64'(A_PER + 1));
      chk("a_data", {a_busy, a_data}, {1'b0, tbl[v].b});
      a_ready = 1;
      @(negedge clock);
      a_ready = 0;
      chk("a_valid_fall", {a_valid, a_busy, a_rst}, 3'b001);
    end

`ifdef PUF_SEQ_MAJORITY_EN
    @(negedge clock);
    a_base = a_evals; a_glitch_on = 1;
    a_seed = 16'h0033; a_start = 1;
    @(negedge clock);
    a_start = 0;
    lat = 0;
    while (!a_valid && lat < A_PER + 100) begin
      @(negedge clock); lat++;
    end
    chk("maj_glitch", a_data, 1'b1);
    a_glitch_on = 0; a_ready = 1;
    @(negedge clock);
    a_ready = 0;
`endif

    for (int k = 0; k < 6; k++) begin
      sd = (k == 0) ? 16'h0000 : 16'($urandom);
      @(negedge clock);
      b_seed = sd; b_start = 1;
      @(negedge clock);
      b_start = 0;
      lat = 0;
      while (!b_valid && lat < BB * B_PER + 50) begin
        @(negedge clock); lat++;
        b_start = (lat == 10);
        b_seed  = 16'($urandom);
      end
      b_start = 0;
      exp64 = m_resp(sd, BB);
      chk("b_latency", 64'(lat), 64'(BB * B_PER + 1));
      chk("b_data", b_data, exp64);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      chk("b_valid_hold", b_valid, 1'b1);
      b_ready = 1;
      @(negedge clock);
      b_ready = 0;
    end

    // reset during the RUN phase of bit 5
    @(negedge clock);
    a_base = b_evals;
    b_seed = 16'h1234; b_start = 1;
    @(negedge clock);
    b_start = 0;
    lat = 0;
    while (b_evals - a_base < 5 * EPB + 1 && lat < BB * B_PER) begin
      @(negedge clock); lat++;
    end
    repeat (5) @(negedge clock);
    chk("b_in_run", {b_en, b_busy}, 2'b11);
    reset_n = 0;
    @(negedge clock);
    chk("mid_reset",
        {b_rst, b_en, b_busy, b_valid, b_sel1, b_sel2, b_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0});
    reset_n = 1;
    seen = 0;
    repeat (BB * B_PER + 20) begin
      @(negedge clock);
      if (b_valid || b_busy) seen = 1;
    end
    chk("no_valid_after_reset", seen, 1'b0);

    // hold in DONE with ready low and stray start pulses
    @(negedge clock);
    sd = 16'($urandom);
    b_seed = sd; b_start = 1;
    @(negedge clock);
    b_start = 0;
    lat = 0;
    while (!b_valid && lat < BB * B_PER + 50) begin
      @(negedge clock); lat++;
    end
    exp64 = m_resp(sd, BB);
    chk("b_data2", b_data, exp64);
    snap = b_data; stable = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!b_valid || b_busy || b_data !== snap) stable = 0;
      b_start = (i % 7 == 0);
      b_seed  = 16'($urandom);
    end
    b_start = 0;
    @(negedge clock);
    if (!b_valid || b_busy || b_data !== snap) stable = 0;
    chk("done_stable", stable, 1'b1);
    b_ready = 1; b_start = 1;
    @(negedge clock);
    b_ready = 0; b_start = 0;
    chk("done_exit", {b_valid, b_busy, b_rst, b_en}, 4'b0010);
    @(negedge clock);
    chk("start_dropped", {b_busy, b_valid}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Autonomous controller that drives the ring-oscillator PUF array's control inputs (`select1`, `select2`, `enable`, `reset`) and reads back its single-bit comparison output. It builds a multi-bit response word from one seed. A 16-bit LFSR expands the seed into a sequence of oscillator pairs. The sequencer evaluates each pair and shifts the result into a response register. It replaces manual VIO control in production builds and sits between the host/test logic and the PUF core.

## Interface
- `RESP_BITS`, 32: response word width (number of pair evaluations), 1..64.
- `RST_CYCLES`, 4: cycles `ro_reset` is held high before each evaluation, ≥1.
- `WINDOW_CYCLES`, 4095: PUF core's reference-count window (its clock-counter terminal count).
- `SETTLE_CYCLES`, 8: extra cycles after the window before sampling, ≥3. This covers the synchronizer plus async counter settle.
- `clock` in 1: single system clock. All logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request pulse. Accepted only in IDLE.
- `seed` in 16: LFSR seed, sampled when `start` is accepted.
- `puf_in` in 1: PUF comparison output, asynchronous to `clock`.
- `ro_select1` out 4: oscillator index for counter 1.
- `ro_select2` out 4: oscillator index for counter 2.
- `ro_enable` out 1: oscillator/counter enable to the PUF core.
- `ro_reset` out 1: active-high counter reset to the PUF core.
- `busy` out 1: high from start acceptance until DONE is entered.
- `resp_valid` out 1: response word available.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out RESP_BITS: response; bit i is the result of evaluation i.

## Operation
- States: IDLE, PRESET, RUN, SAMPLE, NEXT, DONE.
- **IDLE:** `ro_reset`=1, `ro_enable`=0. On `start`:
  - Load the LFSR with `seed`; a seed of 16'h0000 is replaced by 16'hACE1.
  - Clear the bit index and `resp_data`.
  - Go to PRESET.
- **Pair derivation:** `ro_select1`=lfsr[3:0] and `ro_select2`=lfsr[7:4].
  - If they are equal, `ro_select2`=lfsr[3:0]^4'h1.
  - Selects are registered and stable throughout PRESET/RUN/SAMPLE.
- **PRESET:** `ro_reset`=1, `ro_enable`=0 for RST_CYCLES, then go to RUN.
- **RUN:** `ro_reset`=0, `ro_enable`=1 for WINDOW_CYCLES+SETTLE_CYCLES, then go to SAMPLE.
- **SAMPLE:** one cycle.
  - Capture the synchronized `puf_in` into `resp_data[bit_index]`.
  - Drop `ro_enable` to 0.
- **NEXT:** one cycle.
  - Advance the LFSR one step. The polynomial is x^16+x^14+x^13+x^11+1 (Fibonacci, shift left, feedback into bit 0).
  - Increment the bit index.
  - If the index reaches RESP_BITS, go to DONE; otherwise go to PRESET.
- **DONE:** `ro_reset`=1, `ro_enable`=0, `busy`=0, `resp_valid`=1, `resp_data` held.
  - On `resp_ready`=1, clear `resp_valid` and go to IDLE.
- `puf_in` passes through a 2-flop synchronizer before use.
- `start` is ignored outside IDLE, including in DONE.
- `start` and `resp_ready` in the same cycle in DONE: the response is consumed, `start` is dropped, and the next state is IDLE.
- The single timer counter is 16 bits wide and reloads on every state entry. No terminal count exceeds 65535; this is a parameter constraint checked by an elaboration assertion.

## Timing
- Reset values: `ro_select1`=0, `ro_select2`=0, `ro_enable`=0, `ro_reset`=1, `busy`=0, `resp_valid`=0, `resp_data`=0, state IDLE, LFSR=16'hACE1.
- `reset_n` low mid-evaluation returns every output to its reset value on the next edge. The partial response is discarded.
- Start acceptance: `busy`=1 and `ro_reset`=1 on the edge that samples `start`. First PRESET cycle is that next cycle.
- Per-bit period = RST_CYCLES + WINDOW_CYCLES + SETTLE_CYCLES + 2 = 4109 cycles with defaults.
- `resp_valid` rises RESP_BITS×period + 1 cycles after acceptance.
- `resp_valid` falls on the edge after the `resp_ready`=1 sample.
- Selects change only in NEXT, while `ro_enable`=0 and before `ro_reset` is reasserted.

## Configuration
- `PUF_SEQ_MAJORITY_EN` defined:
  - Each pair is evaluated 3 times (PRESET/RUN/SAMPLE ×3, same selects).
  - The stored bit is the 2-of-3 majority.
  - Per-bit period becomes 3×(RST+WIN+SETTLE+1)+1.
- Undefined: single evaluation per pair, as in Operation.

## Structure
- Shared package `puf_seq_pkg` holds:
  - the state enum;
  - LFSR polynomial/taps;
  - the zero-seed substitute 16'hACE1;
  - the pair-derivation function.
- One sub-module: `puf_lfsr16` (load, step, 16-bit state out).
- The synchronizer, timer, and FSM stay in the top module.

## Test plan
- PUF model `puf_in`=(select1>select2). Seed 16'h0021, RESP_BITS=1 → selects 1/2, `resp_data`=0.
  - `resp_valid` appears 4110 cycles after start.
- Seed 16'h0033 → equal pair forced to selects 3/2, bit0=1.
- Seed 0 → LFSR loads 16'hACE1; first selects 1/14.
- `reset_n` low mid-RUN of bit 5 → `ro_reset`=1, `ro_enable`=0, `busy`=0 next edge. No `resp_valid` follows.
- `resp_ready` held low 100 cycles in DONE → data and valid stable. `start` pulses are ignored. `resp_ready` high → IDLE next edge.
- With `PUF_SEQ_MAJORITY_EN`, model glitches `puf_in` on the 2nd evaluation only → stored bit equals the 1st/3rd value.
